// File: rtl/proximity_pkg.sv
// Shared constants and state encoding for the ultrasonic ranger controller.
package proximity_pkg;

    localparam int DEF_TRIG_CYCLES    = 500;      // 10 us at 50 MHz
    localparam int DEF_PERIOD_CYCLES  = 3000000;  // 60 ms trigger-to-trigger
    localparam int DEF_THRESH_CYCLES  = 58000;    // ~20 cm
    localparam int DEF_TIMEOUT_CYCLES = 1250000;  // 25 ms
    localparam int DEF_CNT_W          = 22;

    typedef enum logic [1:0] {
        TRIG    = 2'd0,
        WAIT_HI = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw echo pin plus a registered copy
// used to form single-cycle rise/fall strobes on the synchronized level.
module echo_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic echo_in,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // metastability chain, then one extra stage for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= echo_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign echo_s = s2;
    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;

endmodule

// File: rtl/proximity_sensor.sv
// HC-SR04-style ranger controller: periodic trigger, echo width
// measurement and a registered "too close" flag for the drive logic.
module proximity_sensor
    import proximity_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int THRESH_CYCLES  = DEF_THRESH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    output logic trig,
    input  logic Echo,
    output logic crash
);

    localparam logic [CNT_W-1:0] TRIG_C   = CNT_W'(TRIG_CYCLES);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT_CYCLES);
    // The rise cycle is a high cycle already spent in WAIT_HI, so the true
    // pulse width is width+1; comparing against THRESH-1 accounts for it.
    localparam logic [CNT_W-1:0] THR_M1   = CNT_W'(THRESH_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] width, width_n;
    logic             trig_n, crash_n;
    logic             wrap;
    logic             echo_s, rise, fall;

    echo_sync u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .echo_in (Echo),
        .echo_s  (echo_s),
        .rise    (rise),
        .fall    (fall)
    );

    assign wrap = (pcnt == PER_LAST);

    // free-running period counter; its wrap restarts the trigger cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pcnt <= '0;
        else if (wrap)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    // state, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= TRIG;
            cnt   <= '0;
            width <= '0;
            trig  <= 1'b0;
            crash <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            width <= width_n;
            trig  <= trig_n;
            crash <= crash_n;
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        width_n = width;
        trig_n  = 1'b0;
        crash_n = crash;

        case (state)
            TRIG: begin
                if (cnt < TRIG_C) begin
                    trig_n = 1'b1;
                    cnt_n  = cnt + 1'b1;
                end else begin
                    cnt_n   = '0;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rise) begin
                    width_n = '0;
                    cnt_n   = '0;
                    state_n = MEASURE;
                end else if (cnt >= TO_LAST) begin
                    crash_n = 1'b0;
                    cnt_n   = '0;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    crash_n = (width < THR_M1);
                    state_n = HOLD;
                end else if (width >= TO_C) begin
                    // echo stuck high: report no object
                    crash_n = 1'b0;
                    state_n = HOLD;
                end else if (echo_s) begin
                    width_n = width + 1'b1;
                end
            end
            HOLD: begin
                state_n = HOLD;
            end
            default: state_n = TRIG;
        endcase

        // period wrap overrides whatever the FSM was doing
        if (wrap) begin
            state_n = TRIG;
            cnt_n   = '0;
            trig_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_proximity_sensor.sv
// Directed bench for proximity_sensor with small timing parameters.
module tb_proximity_sensor;

    logic clock;
    logic reset_n;
    logic trig;
    logic Echo;
    logic crash;

    int errs = 0;
    int nchk = 0;

    proximity_sensor #(
        .TRIG_CYCLES    (4),
        .PERIOD_CYCLES  (200),
        .THRESH_CYCLES  (20),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (22)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .trig    (trig),
        .Echo    (Echo),
        .crash   (crash)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // wait for trig to go high (sampled #1 after a rising edge)
    task automatic wait_trig_rise();
        int n = 0;
        while (trig !== 1'b1 && n < 400) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 400) chk("trig_rise_wait", 32'(n < 400), 32'd1);
    endtask

    // wait for the next trigger pulse to finish; returns #1 after the edge
    // on which trig dropped (FSM now in WAIT_HI)
    task automatic wait_trig_fall();
        int n = 0;
        wait_trig_rise();
        while (trig !== 1'b0 && n < 400) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 400) chk("trig_fall_wait", 32'(n < 400), 32'd1);
    endtask

    // echo pulse of n clocks right after trig falls; crash must keep its
    // previous value two clocks after the fall and show the new one at three
    task automatic do_meas(input string tag, input int n, input logic exp, input logic prev);
        wait_trig_fall();
        Echo = 1'b1;
        repeat (n) @(posedge clock);
        #1 Echo = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk({tag, "_prev"}, 32'(crash), 32'(prev));
        @(posedge clock);
        #1 chk(tag, 32'(crash), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        Echo    = 1'b0;
        repeat (3) @(posedge clock);
        #1 chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_crash", 32'(crash), 32'd0);

        // release between edges; trig high for edges 1..4
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
            chk($sformatf("trig_edge%0d", k), 32'(trig), 32'(k <= 4));
        end
        chk("crash_after_rst", 32'(crash), 32'd0);

        // next trigger at edge 201
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (trig !== 1'b1 && n < 400);
        chk("period_edges", 32'(n), 32'd196);

        // far, near, boundary widths
        do_meas("far50", 50, 1'b0, 1'b0);
        do_meas("near5", 5, 1'b1, 1'b0);
        wait_trig_rise();
        chk("near_hold", 32'(crash), 32'd1);
        do_meas("w20", 20, 1'b0, 1'b1);
        do_meas("w19", 19, 1'b1, 1'b0);

        // no echo at all -> timeout clears crash
        wait_trig_fall();
        repeat (110) @(posedge clock);
        #1 chk("no_echo", 32'(crash), 32'd0);

        // echo stuck high
        do_meas("near5b", 5, 1'b1, 1'b0);
        wait_trig_fall();
        Echo = 1'b1;
        repeat (50) @(posedge clock);
        #1 chk("stuck_mid", 32'(crash), 32'd1);
        repeat (60) @(posedge clock);
        #1 chk("stuck_hi", 32'(crash), 32'd0);
        Echo = 1'b0;

        // short pulse wholly inside TRIG is ignored -> timeout result
        do_meas("near5c", 5, 1'b1, 1'b0);
        wait_trig_rise();
        Echo = 1'b1;
        @(posedge clock);
        #1 Echo = 1'b0;
        wait_trig_fall();
        repeat (110) @(posedge clock);
        #1 chk("trig_ignore", 32'(crash), 32'd0);

        // short pulse during HOLD is ignored
        Echo = 1'b1;
        repeat (5) @(posedge clock);
        #1 Echo = 1'b0;
        repeat (10) @(posedge clock);
        #1 chk("hold_ignore", 32'(crash), 32'd0);

        // reset mid-measurement
        do_meas("near5d", 5, 1'b1, 1'b0);
        wait_trig_fall();
        Echo = 1'b1;
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk("mid_rst_crash", 32'(crash), 32'd0);
        chk("mid_rst_trig", 32'(trig), 32'd0);
        Echo = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1 chk("restart_trig", 32'(trig), 32'd1);
        do_meas("after_rst", 5, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
